// File: rtl/router_register.sv
// Router datapath register block: latches the header, stages payload bytes to the
// FIFO, holds a byte across FIFO-full, and checks packet parity.
module router_register (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic       fifo_full,
  input  logic       rst_int_reg,
  input  logic       detect_add,
  input  logic       lfd_state,
  input  logic       ld_state,
  input  logic       laf_state,
  input  logic       full_state,
  output logic       parity_done,
  output logic       low_pkt_valid,
  output logic       err,
  output logic [7:0] dout
);

  logic [7:0] header_byte_q, header_byte_d;
  logic [7:0] full_state_byte_q, full_state_byte_d;
  logic [7:0] internal_parity_q, internal_parity_d;
  logic [7:0] packet_parity_q, packet_parity_d;
  logic [7:0] dout_q, dout_d;
  logic       parity_done_q, parity_done_d;
  logic       low_pkt_valid_q, low_pkt_valid_d;
  logic       err_q, err_d;

  always_comb begin
    header_byte_d     = header_byte_q;
    full_state_byte_d = full_state_byte_q;
    internal_parity_d = internal_parity_q;
    packet_parity_d   = packet_parity_q;
    dout_d            = dout_q;
    parity_done_d     = parity_done_q;
    low_pkt_valid_d   = low_pkt_valid_q;
    err_d             = err_q;

    // Address 2'b11 does not exist, so such a header is ignored.
    if (detect_add && pkt_valid && (data_in[1:0] != 2'b11))
      header_byte_d = data_in;

    if (lfd_state)                    dout_d = header_byte_q;
    else if (ld_state && !fifo_full)  dout_d = data_in;
    else if (laf_state)               dout_d = full_state_byte_q;

    // Capture the byte the FIFO refused so laf_state can replay it.
    if (ld_state && fifo_full)
      full_state_byte_d = data_in;

    if (detect_add)                                internal_parity_d = 8'h00;
    else if (lfd_state)                            internal_parity_d = internal_parity_q ^ header_byte_q;
    else if (ld_state && pkt_valid && !full_state) internal_parity_d = internal_parity_q ^ data_in;

    if (detect_add)                    packet_parity_d = 8'h00;
    else if (ld_state && !pkt_valid)   packet_parity_d = data_in;

    if (rst_int_reg)                   low_pkt_valid_d = 1'b0;
    else if (ld_state && !pkt_valid)   low_pkt_valid_d = 1'b1;

    // Parity byte either goes straight through, or arrives while full and is
    // replayed later from laf_state.
    if (detect_add)
      parity_done_d = 1'b0;
    else if ((ld_state && !fifo_full && !pkt_valid) ||
             (laf_state && low_pkt_valid_q && !parity_done_q))
      parity_done_d = 1'b1;

    if (detect_add)         err_d = 1'b0;
    else if (parity_done_q) err_d = (internal_parity_q != packet_parity_q);
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      header_byte_q     <= 8'h00;
      full_state_byte_q <= 8'h00;
      internal_parity_q <= 8'h00;
      packet_parity_q   <= 8'h00;
      dout_q            <= 8'h00;
      parity_done_q     <= 1'b0;
      low_pkt_valid_q   <= 1'b0;
      err_q             <= 1'b0;
    end else begin
      header_byte_q     <= header_byte_d;
      full_state_byte_q <= full_state_byte_d;
      internal_parity_q <= internal_parity_d;
      packet_parity_q   <= packet_parity_d;
      dout_q            <= dout_d;
      parity_done_q     <= parity_done_d;
      low_pkt_valid_q   <= low_pkt_valid_d;
      err_q             <= err_d;
    end
  end

  assign dout          = dout_q;
  assign parity_done   = parity_done_q;
  assign low_pkt_valid = low_pkt_valid_q;
  assign err           = err_q;

endmodule

// File: tb/tb_router_register.sv
// Directed bench for router_register: packet flows, parity error, invalid address,
// FIFO-full replay, rst_int_reg and mid-packet reset.
module tb_router_register;

  logic       clock = 1'b0;
  logic       resetn, pkt_valid, fifo_full, rst_int_reg;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic [7:0] data_in;
  logic       parity_done, low_pkt_valid, err;
  logic [7:0] dout;

  int n_checks = 0;
  int n_fail   = 0;

  router_register dut (
    .clock        (clock),
    .resetn       (resetn),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .rst_int_reg  (rst_int_reg),
    .detect_add   (detect_add),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .err          (err),
    .dout         (dout)
  );

  always #5 clock = ~clock;

  // Apply one cycle of FSM strobes and data, then sample 1 time unit after the edge.
  task automatic cyc(input logic da, input logic lfd, input logic ld, input logic laf,
                     input logic fs, input logic pv, input logic ff, input logic [7:0] d);
    detect_add = da; lfd_state = lfd; ld_state = ld; laf_state = laf;
    full_state = fs; pkt_valid = pv; fifo_full = ff; data_in = d;
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    resetn = 1'b1; rst_int_reg = 1'b0;
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
    resetn = 1'b0;
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h exp 00", dout); end
    n_checks++; if (parity_done !== 1'b0) begin n_fail++; $display("FAIL reset_parity_done got %b exp 0", parity_done); end
    n_checks++; if (low_pkt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_low_pkt_valid got %b exp 0", low_pkt_valid); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
  endtask

  // Header 16 + payload 01 23 45 67 89; correct parity = 9F.
  task automatic run_packet(input logic [7:0] par, input logic exp_err, input string nm);
    logic [7:0] pl [5];
    pl = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89};
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h16);
    n_checks++; if (parity_done !== 1'b0) begin n_fail++; $display("FAIL %s_pd_clear got %b exp 0", nm, parity_done); end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    n_checks++; if (dout !== 8'h16) begin n_fail++; $display("FAIL %s_hdr_dout got %h exp 16", nm, dout); end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, pl[i]);
      n_checks++; if (dout !== pl[i]) begin n_fail++; $display("FAIL %s_payload%0d got %h exp %h", nm, i, dout, pl[i]); end
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, par);
    n_checks++; if (dout !== par) begin n_fail++; $display("FAIL %s_par_dout got %h exp %h", nm, dout, par); end
    n_checks++; if (low_pkt_valid !== 1'b1) begin n_fail++; $display("FAIL %s_low_pkt_valid got %b exp 1", nm, low_pkt_valid); end
    n_checks++; if (parity_done !== 1'b1) begin n_fail++; $display("FAIL %s_parity_done got %b exp 1", nm, parity_done); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    n_checks++; if (err !== exp_err) begin n_fail++; $display("FAIL %s_err got %b exp %b", nm, err, exp_err); end
    n_checks++; if (dout !== par) begin n_fail++; $display("FAIL %s_dout_hold got %h exp %h", nm, dout, par); end
  endtask

  task automatic test_good_packet;
    run_packet(8'h9F, 1'b0, "good");
  endtask

  task automatic test_bad_parity;
    run_packet(8'h9E, 1'b1, "bad");
  endtask

  task automatic test_invalid_addr;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h16);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h17);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    n_checks++; if (dout !== 8'h16) begin n_fail++; $display("FAIL invalid_addr_hdr got %h exp 16", dout); end
    // detect_add also clears a sticky parity_done/err from the previous packet
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL invalid_addr_err_clear got %b exp 0", err); end
  endtask

  // Header 16, payload 3C, A5 (refused while full), parity 8F also arrives while full.
  task automatic test_fifo_full;
    resetn = 1'b1; cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); resetn = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h16);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5);
    n_checks++; if (dout !== 8'h3C) begin n_fail++; $display("FAIL full_dout_hold got %h exp 3C", dout); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
    n_checks++; if (dout !== 8'h3C) begin n_fail++; $display("FAIL full_state_hold got %h exp 3C", dout); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    n_checks++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL laf_replay got %h exp A5", dout); end
    n_checks++; if (parity_done !== 1'b0) begin n_fail++; $display("FAIL laf_no_pd got %b exp 0", parity_done); end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h8F);
    n_checks++; if (low_pkt_valid !== 1'b1) begin n_fail++; $display("FAIL full_lpv got %b exp 1", low_pkt_valid); end
    n_checks++; if (parity_done !== 1'b0) begin n_fail++; $display("FAIL full_par_pd got %b exp 0", parity_done); end
    n_checks++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL full_par_hold got %h exp A5", dout); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    n_checks++; if (dout !== 8'h8F) begin n_fail++; $display("FAIL laf_par_replay got %h exp 8F", dout); end
    n_checks++; if (parity_done !== 1'b1) begin n_fail++; $display("FAIL laf_pd got %b exp 1", parity_done); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL full_err got %b exp 0", err); end
  endtask

  task automatic test_rst_int_reg;
    rst_int_reg = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    rst_int_reg = 1'b0;
    n_checks++; if (low_pkt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_int_clear got %b exp 0", low_pkt_valid); end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    n_checks++; if (low_pkt_valid !== 1'b1) begin n_fail++; $display("FAIL lpv_set got %b exp 1", low_pkt_valid); end
    // rst_int_reg wins over a simultaneous set
    rst_int_reg = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    rst_int_reg = 1'b0;
    n_checks++; if (low_pkt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_int_priority got %b exp 0", low_pkt_valid); end
  endtask

  // Reset mid-packet, then header 2A, payload 11, parity 3B.
  task automatic test_reset_mid_packet;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h16);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55);
    resetn = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77);
    resetn = 1'b0;
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL midrst_dout got %h exp 00", dout); end
    n_checks++; if (low_pkt_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_lpv got %b exp 0", low_pkt_valid); end
    n_checks++; if (parity_done !== 1'b0) begin n_fail++; $display("FAIL midrst_pd got %b exp 0", parity_done); end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h2A);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    n_checks++; if (dout !== 8'h2A) begin n_fail++; $display("FAIL midrst_hdr got %h exp 2A", dout); end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11);
    n_checks++; if (dout !== 8'h11) begin n_fail++; $display("FAIL midrst_payload got %h exp 11", dout); end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3B);
    n_checks++; if (parity_done !== 1'b1) begin n_fail++; $display("FAIL midrst_pd_set got %b exp 1", parity_done); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL midrst_err got %b exp 0", err); end
  endtask

  initial begin
    resetn = 1'b1; rst_int_reg = 1'b0; pkt_valid = 1'b0; fifo_full = 1'b0;
    detect_add = 1'b0; lfd_state = 1'b0; ld_state = 1'b0; laf_state = 1'b0;
    full_state = 1'b0; data_in = 8'h00;
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_invalid_addr();
    test_fifo_full();
    test_rst_int_reg();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_register.md
ROUTER_REGISTER -- requirements
Module: router_register

Interface
REQ-001 SHALL have port clock, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: synchronous reset, active-high despite the name; sampled only on rising clock.
REQ-003 SHALL have port pkt_valid, input, 1: high while header/payload bytes are on data_in; low on the cycle carrying the parity byte.
REQ-004 SHALL have port data_in, input, 8: packet byte stream; header = {payload_len[7:2], addr[1:0]}.
REQ-005 SHALL have port fifo_full, input, 1: destination FIFO cannot accept a byte this cycle.
REQ-006 SHALL have port rst_int_reg, input, 1: clears low_pkt_valid.
REQ-007 SHALL have ports detect_add, lfd_state, ld_state, laf_state, full_state, inputs, 1 bit each: FSM state decodes (header detect, load first data, load data, load after full, FIFO full wait).
REQ-008 SHALL have port parity_done, output, 1: parity byte has been received and checking may occur.
REQ-009 SHALL have port low_pkt_valid, output, 1: pkt_valid fell while in ld_state.
REQ-010 SHALL have port err, output, 1: computed parity differs from received parity byte.
REQ-011 SHALL have port dout, output, 8: byte presented to the FIFO.

Function
REQ-012 Internal registers SHALL be: header_byte[7:0], full_state_byte[7:0], internal_parity[7:0], packet_parity[7:0]; all outputs registered.
REQ-013 header_byte SHALL load data_in when detect_add & pkt_valid & data_in[1:0] != 2'b11; address 11 is invalid and leaves header_byte unchanged.
REQ-014 dout SHALL update, in priority order: lfd_state -> header_byte; ld_state & !fifo_full -> data_in; laf_state -> full_state_byte; otherwise hold.
REQ-015 full_state_byte SHALL load data_in when ld_state & fifo_full (byte not lost while FIFO full); replayed on dout in laf_state.
REQ-016 internal_parity SHALL clear on detect_add; XOR with header_byte in lfd_state; XOR with data_in when ld_state & pkt_valid & !full_state; else hold.
REQ-017 packet_parity SHALL clear on detect_add; load data_in when ld_state & !pkt_valid; else hold.
REQ-018 low_pkt_valid SHALL clear when rst_int_reg; else set when ld_state & !pkt_valid; else hold (rst_int_reg wins if simultaneous).
REQ-019 parity_done SHALL clear on detect_add; set when (ld_state & !fifo_full & !pkt_valid) or (laf_state & low_pkt_valid & !parity_done); else hold (sticky until next detect_add).
REQ-020 err SHALL clear on detect_add; when parity_done=1, load (internal_parity != packet_parity); else hold; thus err is valid one clock after parity_done rises.
REQ-021 Latency: byte on data_in appears on dout one clock later; header appears on dout one clock after lfd_state cycle.
REQ-022 Simultaneous detect_add with other state strobes SHALL not occur (FSM one-hot); detect_add priority wins for clears.

Reset
REQ-023 resetn=1 at a rising edge SHALL force dout=8'h00, parity_done=0, low_pkt_valid=0, err=0 and all internal registers to 0, overriding every other input.
REQ-024 Reset asserted mid-packet SHALL abandon the packet; next packet starts cleanly at detect_add.

Verification
REQ-025 Reset: resetn=1 one clock with arbitrary inputs -> dout=00, parity_done=0, low_pkt_valid=0, err=0.
REQ-026 Good packet: detect_add+pkt_valid with data_in=8'h16 (len 5, addr 2), lfd_state next cycle, 5 random payload bytes in ld_state, then pkt_valid=0 with data_in=XOR of all 6 bytes -> dout sequence 16,payload..., parity; low_pkt_valid=1 and parity_done=1 after parity cycle; err=0 one clock later.
REQ-027 Bad parity: same as REQ-026 but final byte = correct parity ^ 8'h01 -> parity_done=1, then err=1.
REQ-028 Invalid address: detect_add+pkt_valid with data_in=8'h17 after a prior header 8'h16 -> header_byte remains 16; lfd_state drives dout=16.
REQ-029 FIFO full: in ld_state with fifo_full=1 and data_in=8'hA5 -> dout holds; later laf_state -> dout=A5; with low_pkt_valid=1, laf_state sets parity_done.
REQ-030 rst_int_reg: with low_pkt_valid=1, pulse rst_int_reg -> low_pkt_valid=0 next clock.
